// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: issue/sequencing control for a multi-cycle multiply/divide
// unit that writes the HI/LO register pair, plus the pipeline stall it implies.
// The FSM walks IDLE -> RUN (counted) -> WRITE (one cycle) -> IDLE.
// A divide by zero skips RUN and goes straight to WRITE with HI/LO writes suppressed.
// Optional feature: define HILO_FORWARD_EN to let mfhi/mflo in the WRITE cycle
// take the new result through the Fwd_Sel forwarding path instead of stalling.
module muldiv_hilo_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       IsDiv,
  input  logic       DivByZero,
  input  logic       HiLoRead,
  input  logic       LoadUse,
  output logic       HiLo_En,
  output logic       PC_En,
  output logic       IFID_En,
  output logic       IDEX_Flush,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero,
  output logic [5:0] Cnt
`ifdef HILO_FORWARD_EN
  ,
  output logic       Fwd_Sel
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  logic [1:0] r_state;
  logic [5:0] r_cnt;
  logic       r_dz;

  logic w_accept;
  logic w_pending;
  logic w_stall;

  // An operation is accepted only from IDLE, and a load-use hazard wins over Start.
  assign w_accept = (r_state == S_IDLE) && Start && !LoadUse;

  // HI/LO is still "in flight" for readers; forwarding lets WRITE-cycle reads proceed.
`ifdef HILO_FORWARD_EN
  assign w_pending = (r_state == S_RUN);
  assign Fwd_Sel   = (r_state == S_WRITE);
`else
  assign w_pending = (r_state != S_IDLE);
`endif

  // Combinational stall: the only outputs that depend directly on inputs.
  assign w_stall    = LoadUse | (HiLoRead & w_pending) | (Start & (r_state != S_IDLE));
  assign PC_En      = ~w_stall;
  assign IFID_En    = ~w_stall;
  assign IDEX_Flush = w_stall;

  // Moore outputs decoded from state and the latched divide-by-zero flag.
  assign Busy    = (r_state != S_IDLE);
  assign Done    = (r_state == S_WRITE);
  assign HiLo_En = (r_state == S_WRITE) && !r_dz;
  assign DivZero = (r_state == S_WRITE) && r_dz;
  assign Cnt     = r_cnt;

  // FSM, RUN countdown and divide-by-zero flag; reset aborts any operation.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (IsDiv && DivByZero) begin
              r_state <= S_WRITE;
              r_cnt   <= 6'd0;
              r_dz    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= IsDiv ? DIV_LOAD : MULT_LOAD;
              r_dz    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          // Hold at zero on the last RUN cycle rather than wrapping.
          if (r_cnt == 6'd0) begin
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_dz    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 6'd0;
          r_dz    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: expected per-cycle Moore outputs are
// queued when stimulus is driven and popped after every rising edge.
module tb_muldiv_hilo_ctrl;

  localparam int MC = 4;
  localparam int DC = 32;

  logic       Clk = 1'b0;
  logic       Rst, Start, IsDiv, DivByZero, HiLoRead, LoadUse;
  logic       HiLo_En, PC_En, IFID_En, IDEX_Flush, Busy, Done, DivZero;
  logic [5:0] Cnt;
`ifdef HILO_FORWARD_EN
  logic       Fwd_Sel;
`endif

  muldiv_hilo_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .IsDiv(IsDiv), .DivByZero(DivByZero),
    .HiLoRead(HiLoRead), .LoadUse(LoadUse), .HiLo_En(HiLo_En), .PC_En(PC_En),
    .IFID_En(IFID_En), .IDEX_Flush(IDEX_Flush), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Cnt(Cnt)
`ifdef HILO_FORWARD_EN
    , .Fwd_Sel(Fwd_Sel)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       hilo;
    logic       dz;
    logic [5:0] cnt;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
  endtask

  // Expected sequence for one accepted operation: n RUN cycles then WRITE.
  task automatic push_op(input int n, input logic dz);
    if (!dz) begin
      for (int i = n - 1; i >= 0; i--) q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 6'(i)});
    end
    q.push_back('{1'b1, 1'b1, !dz, dz, 6'd0});
  endtask

  // Advance one clock and compare registered outputs against the next queued entry.
  task automatic tick(input string tag);
    exp_t e;
    exp_t o;
    @(posedge Clk);
    #1;
    ntests++;
    if (q.size() == 0) begin
      nfail++;
      $error("FAIL %s scoreboard empty at t=%0t", tag, $time);
    end else begin
      e = q.pop_front();
      o = '{Busy, Done, HiLo_En, DivZero, Cnt};
      assert (o === e) else begin
        nfail++;
        $error("FAIL %s busy/done/hilo/dz/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
               tag, o.busy, o.done, o.hilo, o.dz, o.cnt, e.busy, e.done, e.hilo, e.dz, e.cnt);
      end
    end
  endtask

  task automatic chk_stall(input string tag, input logic s);
    logic [2:0] o;
    logic [2:0] e;
    #1;
    o = {PC_En, IFID_En, IDEX_Flush};
    e = {~s, ~s, s};
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s pc/ifid/flush got %b want %b", tag, o, e);
    end
  endtask

  initial begin
    logic exp_s;
    Rst = 1'b1; Start = 1'b0; IsDiv = 1'b0; DivByZero = 1'b0;
    HiLoRead = 1'b0; LoadUse = 1'b0;

    // Reset state
    push_idle(2);
    tick("reset0");
    chk_stall("reset_stall", 1'b0);
    tick("reset1");
    Rst = 1'b0;
    HiLoRead = 1'b1;
    chk_stall("idle_hiloread", 1'b0);
    HiLoRead = 1'b0;

    // Multiply with HiLoRead held from cycle 1
    Start = 1'b1; IsDiv = 1'b0;
    chk_stall("mult_issue", 1'b0);
    push_op(MC, 1'b0);
    push_idle(1);
    tick("mult_c1");
    Start = 1'b0; HiLoRead = 1'b1;
    for (int k = 1; k <= MC + 1; k++) begin
`ifdef HILO_FORWARD_EN
      exp_s = (k <= MC);
      ntests++;
      assert (Fwd_Sel === (k == MC + 1)) else begin
        nfail++;
        $error("FAIL fwd_sel c%0d got %b want %b", k, Fwd_Sel, (k == MC + 1));
      end
`else
      exp_s = 1'b1;
`endif
      chk_stall($sformatf("mult_hiloread_c%0d", k), exp_s);
      tick($sformatf("mult_c%0d", k + 1));
    end
    chk_stall("mult_after_idle", 1'b0);
    HiLoRead = 1'b0;

    // Divide: 32 RUN cycles, single WRITE
    Start = 1'b1; IsDiv = 1'b1;
    push_op(DC, 1'b0);
    push_idle(1);
    tick("div_c1");
    Start = 1'b0; IsDiv = 1'b0;
    for (int k = 2; k <= DC + 2; k++) tick($sformatf("div_c%0d", k));

    // Divide by zero: WRITE immediately, no HI/LO write
    Start = 1'b1; IsDiv = 1'b1; DivByZero = 1'b1;
    push_op(0, 1'b1);
    push_idle(1);
    tick("dz_c1");
    Start = 1'b0; IsDiv = 1'b0; DivByZero = 1'b0;
    tick("dz_c2");

    // LoadUse blocks Start; then accepted; second Start held through RUN/WRITE
    Start = 1'b1; LoadUse = 1'b1;
    chk_stall("loaduse_stall", 1'b1);
    push_idle(1);
    tick("loaduse_noaccept");
    LoadUse = 1'b0;
    chk_stall("start_idle", 1'b0);
    push_op(MC, 1'b0);
    push_idle(1);
    push_op(MC, 1'b0);
    push_idle(1);
    tick("b2b_c1");
    for (int k = 1; k <= MC + 1; k++) begin
      chk_stall($sformatf("busy_start_c%0d", k), 1'b1);
      tick($sformatf("b2b_c%0d", k + 1));
    end
    chk_stall("b2b_accept_idle", 1'b0);
    tick("b2b_second_c1");
    Start = 1'b0;
    for (int k = 2; k <= MC + 2; k++) tick($sformatf("b2b_second_c%0d", k));

    // Reset during divide RUN
    Start = 1'b1; IsDiv = 1'b1;
    push_op(DC, 1'b0);
    tick("rstdiv_c1");
    Start = 1'b0; IsDiv = 1'b0;
    tick("rstdiv_c2");
    tick("rstdiv_c3");
    Rst = 1'b1;
    q.delete();
    push_idle(6);
    tick("rstdiv_c4");
    Rst = 1'b0;
    for (int k = 5; k <= 9; k++) tick($sformatf("rstdiv_c%0d", k));

    ntests++;
    assert (q.size() == 0) else begin
      nfail++;
      $error("FAIL scoreboard_drain got %0d entries want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
MULDIV_HILO_CTRL -- requirements
Module: muldiv_hilo_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, number of RUN cycles for a multiply (legal 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, number of RUN cycles for a divide (legal 1..63).
REQ-003 SHALL have ports: Clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have: Rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have: Start  in  1  mult/div instruction in ID requests issue.
REQ-006 SHALL have: IsDiv  in  1  1 = divide, 0 = multiply; sampled with Start.
REQ-007 SHALL have: DivByZero  in  1  divisor is zero; sampled with Start.
REQ-008 SHALL have: HiLoRead  in  1  instruction in ID reads HI/LO (mfhi/mflo).
REQ-009 SHALL have: LoadUse  in  1  load-use hazard detected in ID.
REQ-010 SHALL have outputs: HiLo_En  1  enable to HI and LO Reg32; PC_En  1; IFID_En  1; IDEX_Flush  1; Busy  1; Done  1; DivZero  1; Cnt  6  remaining RUN cycles.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, WRITE.
REQ-012 IDLE: Start=1 and LoadUse=0 SHALL accept; normal operand -> RUN with Cnt loaded MULT_CYCLES-1 or DIV_CYCLES-1 per IsDiv.
REQ-013 IDLE: accepted divide with DivByZero=1 SHALL skip RUN -> WRITE next cycle, DivZero flag latched.
REQ-014 RUN: Cnt SHALL decrement by 1 per cycle; at Cnt=0 -> WRITE; no wrap-around below 0.
REQ-015 WRITE: SHALL last exactly one cycle, Done=1, HiLo_En=1 (0 when DivZero flag set), DivZero=flag; -> IDLE, flag cleared.
REQ-016 Latency: Start accepted in cycle 0 -> RUN cycles 1..N, WRITE cycle N+1, HI/LO valid from cycle N+2, IDLE in N+2.
REQ-017 Busy SHALL be 1 in RUN and WRITE, 0 in IDLE; HiLo_En, Done, DivZero SHALL be Moore outputs of state.
REQ-018 Stall SHALL be LoadUse | (HiLoRead & hilo_pending) | (Start & state!=IDLE).
REQ-019 Stall=1 SHALL drive PC_En=0, IFID_En=0, IDEX_Flush=1; Stall=0 SHALL drive PC_En=1, IFID_En=1, IDEX_Flush=0.
REQ-020 LoadUse SHALL take priority over Start: Start in IDLE with LoadUse=1 is not accepted, FSM stays IDLE.
REQ-021 Start while Busy SHALL not be accepted nor disturb the current operation; stall holds until IDLE, then accepted.
REQ-022 Start in the same cycle as WRITE SHALL stall; accepted in following IDLE cycle (no back-to-back overlap).
REQ-023 Stall outputs SHALL be combinational from state and inputs; no other output depends combinationally on inputs.

Reset
REQ-024 Rst=1 at a clock edge SHALL force IDLE, Cnt=0, DivZero flag=0, regardless of state.
REQ-025 During and after reset: HiLo_En=0, Done=0, DivZero=0, Busy=0; stall outputs per REQ-019 from inputs.
REQ-026 Reset mid-RUN SHALL abort with no WRITE cycle and no HiLo_En pulse.

Configuration
REQ-027 Macro HILO_FORWARD_EN SHALL control WRITE-cycle forwarding.
REQ-028 Defined: hilo_pending = (state==RUN); HiLoRead in WRITE does not stall, output Fwd_Sel (1 bit) = 1 in WRITE to select new result into ID.
REQ-029 Undefined: hilo_pending = (state!=IDLE); Fwd_Sel port absent; HiLoRead stalls through WRITE.

Verification
REQ-030 Mult: Start=1, IsDiv=0 in cycle 0 -> Busy cycles 1..5, Cnt 3,2,1,0 in cycles 1..4, HiLo_En=Done=1 in cycle 5 only.
REQ-031 Div: Start=1, IsDiv=1 -> 32 RUN cycles, Cnt 31..0, WRITE in cycle 33, HiLo_En=1 once.
REQ-032 Div by zero: Start=1, IsDiv=1, DivByZero=1 -> WRITE in cycle 1, Done=1, DivZero=1, HiLo_En=0.
REQ-033 HiLoRead held high from cycle 1 after mult start -> PC_En=0, IDEX_Flush=1 cycles 1..5 (1..4 with HILO_FORWARD_EN, Fwd_Sel=1 in 5).
REQ-034 Start with LoadUse=1 in IDLE -> not accepted, Busy=0 next cycle; second Start during RUN -> stall, accepted cycle after WRITE.
REQ-035 Rst=1 in cycle 3 of div -> IDLE cycle 4, Cnt=0, no HiLo_En/Done pulse afterward.
